// File: rtl/cpu_fpu_addsub_issue_if.sv
// Handshake bundle between FPU dispatch, the add/sub issue stage and the FPU adder.
// Signal names are relative to the issue stage: i_* flow into it, o_* flow out of it.
interface cpu_fpu_addsub_issue_if;
   logic        i_request;
   logic [1:0]  i_op;
   logic [31:0] i_op1;
   logic [31:0] i_op2;
   logic        o_ready;
   logic [31:0] o_result;
   logic        o_error;
   logic        o_busy;
   logic        o_add_request;
   logic [31:0] o_add_op1;
   logic [31:0] o_add_op2;
   logic        i_add_ready;
   logic [31:0] i_add_result;

   modport slave (
      input  i_request, i_op, i_op1, i_op2, i_add_ready, i_add_result,
      output o_ready, o_result, o_error, o_busy, o_add_request, o_add_op1, o_add_op2
   );

   modport master (
      output i_request, i_op, i_op1, i_op2, i_add_ready, i_add_result,
      input  o_ready, o_result, o_error, o_busy, o_add_request, o_add_op1, o_add_op2
   );
endinterface

// File: rtl/cpu_fpu_addsub_issue.sv
// Issue stage in front of the single-precision adder: forwards FADD/FSUB to the adder,
// resolves FMIN/FMAX locally, and bounds every adder handshake phase with a watchdog.
module cpu_fpu_addsub_issue #(
   parameter int TIMEOUT = 64
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   cpu_fpu_addsub_issue_if.slave   bus
);

   localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
   localparam logic [31:0] QNAN     = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ADD_REQ     = 3'd1,
      ST_ADD_RELEASE = 3'd2,
      ST_MINMAX      = 3'd3,
      ST_DONE        = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic          want_max_r, want_max_s;
   logic [31:0]   op1_r, op1_s;
   logic [31:0]   op2_r, op2_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          ready_r, ready_s;
   logic [31:0]   result_r, result_s;
   logic          error_r, error_s;
   logic          busy_r, busy_s;
   logic          add_req_r, add_req_s;
   logic [31:0]   add_op1_r, add_op1_s;
   logic [31:0]   add_op2_r, add_op2_s;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Sign-magnitude ordering; -0 sorts below +0 because the sign bits differ.
   function automatic logic fp_less(input logic [31:0] a, input logic [31:0] b);
      logic lt;
      if (a[31] != b[31]) begin
         lt = a[31];
      end else if (a[31] == 1'b0) begin
         lt = (a[30:0] < b[30:0]);
      end else begin
         lt = (a[30:0] > b[30:0]);
      end
      return lt;
   endfunction

   function automatic logic [31:0] fp_minmax(input logic want_max, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      if (is_nan(a) && is_nan(b)) begin
         r = QNAN;
      end else if (is_nan(a)) begin
         r = b;
      end else if (is_nan(b)) begin
         r = a;
      end else if (fp_less(a, b) ^ want_max) begin
         r = a;
      end else begin
         r = b;
      end
      return r;
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (c == CNT_SAT) ? c : c + CW'(1);
   endfunction

   // Next-state and next-output decode for the issue sequencer.
   always_comb begin
      state_s    = state_r;
      want_max_s = want_max_r;
      op1_s      = op1_r;
      op2_s      = op2_r;
      cnt_s      = cnt_r;
      ready_s    = 1'b0;
      result_s   = result_r;
      error_s    = error_r;
      add_req_s  = add_req_r;
      add_op1_s  = add_op1_r;
      add_op2_s  = add_op2_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.i_request) begin
               want_max_s = bus.i_op[0];
               op1_s      = bus.i_op1;
               op2_s      = bus.i_op2;
               error_s    = 1'b0;
               cnt_s      = {CW{1'b0}};
               if (bus.i_op[1] == 1'b0) begin
                  state_s   = ST_ADD_REQ;
                  add_req_s = 1'b1;
                  add_op1_s = bus.i_op1;
                  add_op2_s = bus.i_op[0] ? {~bus.i_op2[31], bus.i_op2[30:0]} : bus.i_op2;
               end else begin
                  state_s = ST_MINMAX;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ADD_REQ: begin
            if (bus.i_add_ready) begin
               result_s  = bus.i_add_result;
               add_req_s = 1'b0;
               cnt_s     = {CW{1'b0}};
               state_s   = ST_ADD_RELEASE;
            end else if (cnt_r == CNT_LAST) begin
               result_s  = QNAN;
               error_s   = 1'b1;
               add_req_s = 1'b0;
               cnt_s     = {CW{1'b0}};
               state_s   = ST_DONE;
            end else begin
               cnt_s = sat_inc(cnt_r);
            end
         end
         ST_ADD_RELEASE: begin
            add_req_s = 1'b0;
            if (!bus.i_add_ready) begin
               cnt_s   = {CW{1'b0}};
               state_s = ST_DONE;
            end else if (cnt_r == CNT_LAST) begin
               error_s = 1'b1;
               cnt_s   = {CW{1'b0}};
               state_s = ST_DONE;
            end else begin
               cnt_s = sat_inc(cnt_r);
            end
         end
         ST_MINMAX: begin
            result_s = fp_minmax(want_max_r, op1_r, op2_r);
            cnt_s    = {CW{1'b0}};
            state_s  = ST_DONE;
         end
         ST_DONE: begin
            if (bus.i_request) begin
               ready_s = 1'b1;
            end else begin
               ready_s = 1'b0;
               cnt_s   = {CW{1'b0}};
               state_s = ST_IDLE;
            end
         end
         default: begin
            state_s   = ST_IDLE;
            add_req_s = 1'b0;
            cnt_s     = {CW{1'b0}};
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State, operand and output registers; reset drops any operation in flight.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_r    <= ST_IDLE;
         want_max_r <= 1'b0;
         op1_r      <= 32'd0;
         op2_r      <= 32'd0;
         cnt_r      <= {CW{1'b0}};
         ready_r    <= 1'b0;
         result_r   <= 32'd0;
         error_r    <= 1'b0;
         busy_r     <= 1'b0;
         add_req_r  <= 1'b0;
         add_op1_r  <= 32'd0;
         add_op2_r  <= 32'd0;
      end else begin
         state_r    <= state_s;
         want_max_r <= want_max_s;
         op1_r      <= op1_s;
         op2_r      <= op2_s;
         cnt_r      <= cnt_s;
         ready_r    <= ready_s;
         result_r   <= result_s;
         error_r    <= error_s;
         busy_r     <= busy_s;
         add_req_r  <= add_req_s;
         add_op1_r  <= add_op1_s;
         add_op2_r  <= add_op2_s;
      end
   end

   assign bus.o_ready       = ready_r;
   assign bus.o_result      = result_r;
   assign bus.o_error       = error_r;
   assign bus.o_busy        = busy_r;
   assign bus.o_add_request = add_req_r;
   assign bus.o_add_op1     = add_op1_r;
   assign bus.o_add_op2     = add_op2_r;

endmodule

// File: doc/cpu_fpu_addsub_issue.md
Name: cpu_fpu_addsub_issue

Overview:
Issue/sequencer stage directly upstream of the single-precision FPU adder. It accepts FADD.S/FSUB.S/FMIN.S/FMAX.S requests from the FPU dispatch level. Add and subtract are forwarded to the adder over its level request/ready handshake; for subtract, the op2 sign is flipped before forwarding. Min and max are resolved locally. A watchdog bounds the adder wait, and the final result is returned on a level handshake of the same style.

Parameters:
TIMEOUT, 64, maximum cycles spent waiting on any single adder handshake phase before the operation is aborted.

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_request  in  1  level request; held high until o_ready seen, then dropped
i_op  in  2  operation: 00 FADD, 01 FSUB, 10 FMIN, 11 FMAX
i_op1  in  32  IEEE-754 single operand 1
i_op2  in  32  IEEE-754 single operand 2
o_ready  out  1  result valid; held until i_request low
o_result  out  32  result word
o_error  out  1  watchdog abort flag, valid with o_ready
o_busy  out  1  high in any state other than IDLE
o_add_request  out  1  adder request, level
o_add_op1  out  32  adder operand 1
o_add_op2  out  32  adder operand 2, sign-adjusted
i_add_ready  in  1  adder result valid
i_add_result  in  32  adder result

Behaviour:
- Async reset, applied immediately: state IDLE; o_ready, o_error, o_add_request cleared to 0; o_result, o_add_op1, o_add_op2 cleared to 0; watchdog count 0. The adder shares i_reset, so reset mid-operation aborts both blocks cleanly. No partial result is delivered.
- IDLE
  - o_ready=0. On an edge with i_request=1: latch i_op, i_op1, i_op2 and clear o_error.
  - FADD/FSUB -> ADD_REQ. FMIN/FMAX -> MINMAX.
- ADD_REQ
  - o_add_request=1, o_add_op1=op1; o_add_op2=op2 for FADD, {~op2[31], op2[30:0]} for FSUB.
  - Sampled i_add_ready=1 -> capture i_add_result, drop o_add_request, reset counter, go ADD_RELEASE.
  - Otherwise the counter increments; counter reaching TIMEOUT-1 -> result 0x7FC00000, o_error=1, drop request, go DONE.
- ADD_RELEASE
  - o_add_request=0. Wait for i_add_ready=0, then go DONE.
  - Same watchdog applies: timeout -> DONE with o_error=1. The captured result is kept in this case.
- MINMAX: single cycle, then DONE. RISC-V semantics:
  - both operands NaN -> 0x7FC00000.
  - exactly one NaN -> the other operand.
  - -0 is less than +0.
  - otherwise ordered by sign-magnitude compare: both negative means larger magnitude is smaller.
  - NaN is exp==0xFF and mantissa!=0. Signalling vs quiet is not distinguished; no flags are raised.
- DONE
  - o_ready=1, o_result stable.
  - i_request=0 -> o_ready=0 (registered), go IDLE.
  - A new request is only accepted from IDLE, so back-to-back operations cost at least one IDLE cycle.
- Latency
  - FMIN/FMAX: o_ready is high 3 edges after the edge sampling i_request (IDLE->MINMAX->DONE).
  - FADD/FSUB: 1 + adder latency + release cycles + 1.
- o_add_op1/o_add_op2 stay stable for the whole of ADD_REQ.
- Out-of-range i_op cannot occur (2-bit field fully decoded).
- Watchdog counter is ceil(log2(TIMEOUT)) bits, saturates, and is cleared on every state entry.

Test Plan:
- FADD 0x3F800000 + 0x40000000, using the real adder -> o_result=0x40400000, o_error=0, o_add_request drops on the cycle after i_add_ready.
- FSUB 0x3F800000 - 0x3F800000 -> o_add_op2=0xBF800000, o_result=0x00000000.
- FMIN(0x80000000, 0x00000000) -> 0x80000000; FMAX of the same pair -> 0x00000000; both with o_ready 3 edges after the request.
- NaN handling:
  - FMAX(0x7FC00001, 0x3F800000) -> 0x3F800000.
  - FMIN(0x7F800001, 0xFFC00000) -> 0x7FC00000.
  - FMIN(0xC0000000, 0xBF800000) -> 0xC0000000.
- Adder model that never asserts ready, TIMEOUT=8 -> o_ready with o_result=0x7FC00000, o_error=1, o_add_request=0; next request succeeds normally.
- i_reset pulsed asynchronously mid-ADD_REQ -> all outputs 0 immediately, state IDLE; i_request still high after reset starts a fresh operation with the correct result.
